// File: rtl/counter_bank_if.sv
// counter_bank_if
//   Bundles the client-facing signals of counter_bank_scheduler.
//   master : client side (drives requests, clears and readback index)
//   slave  : scheduler side (drives grant, wrap, readback value and busy)
//
//   Handshake: inc_req[i] is a level request held until grant[i] is seen
//   high; grant[i] is a one-cycle pulse meaning exactly one increment of
//   counter[i] happened on that edge. Keeping inc_req[i] high requests
//   another increment; dropping it before a grant cancels with no effect.
//   clr_req[i] is a single-cycle command with no acknowledge.
//
//   Signals:
//     inc_req  [NREQ]   per-requester increment request (level)
//     clr_req  [NREQ]   per-counter clear command (pulse)
//     grant    [NREQ]   one-hot grant pulse
//     wrap     [NREQ]   pulse with grant when the counter rolled max->0
//     rd_sel   [SELW]   readback index
//     rd_value [WIDTH]  registered value of counter[rd_sel]
//     busy              any inc_req seen in the previous cycle
interface counter_bank_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    localparam int SELW = $clog2(NREQ);

    logic [NREQ-1:0]  inc_req;
    logic [NREQ-1:0]  clr_req;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  wrap;
    logic [SELW-1:0]  rd_sel;
    logic [WIDTH-1:0] rd_value;
    logic             busy;

    modport master (
        output inc_req, clr_req, rd_sel,
        input  grant, wrap, rd_value, busy
    );

    modport slave (
        input  inc_req, clr_req, rd_sel,
        output grant, wrap, rd_value, busy
    );
endinterface

// File: rtl/counter_bank_scheduler.sv
// counter_bank_scheduler
//   Bank of NREQ wrap-around WIDTH-bit counters sharing one incrementer.
//   Each cycle one requester is chosen round-robin and its counter is
//   bumped; clears are applied per counter in parallel and take priority
//   over an increment of the same counter. Readback is registered and
//   shows the value the counter holds after the current edge.
//
//   Ports:
//     clk  : clock, all updates on posedge
//     rst  : asynchronous active-high reset
//     bus  : counter_bank_if.slave (inc_req, clr_req, rd_sel in;
//            grant, wrap, rd_value, busy out)
//   The interface instance must use the same NREQ/WIDTH as this module.
module counter_bank_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input logic           clk,
    input logic           rst,
    counter_bank_if.slave bus
);
    localparam int SELW = $clog2(NREQ);

    // Index of the requester base+off, taken modulo NREQ.
    function automatic logic [SELW-1:0] rr_index(input logic [SELW-1:0] base,
                                                 input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return SELW'(s);
    endfunction

    logic [WIDTH-1:0] cnt_q [NREQ];
    logic [WIDTH-1:0] cnt_d [NREQ];
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [NREQ-1:0]  wrap_q, wrap_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             busy_q;

    logic [NREQ-1:0]  eligible;
    logic             found;
    logic [SELW-1:0]  winner;
    logic [SELW-1:0]  scan_idx;

    // A counter being cleared cannot win this cycle, so the pointer only
    // moves past requesters that were actually served.
    always_comb begin
        eligible = bus.inc_req & ~bus.clr_req;
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = rr_index(ptr_q, i);
            if (!found && eligible[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NREQ; j++) begin
            cnt_d[j]  = cnt_q[j];
            wrap_d[j] = 1'b0;
            if (bus.clr_req[j]) begin
                cnt_d[j] = '0;
            end else if (found && winner == SELW'(j)) begin
                cnt_d[j]  = cnt_q[j] + 1'b1;
                wrap_d[j] = &cnt_q[j];
            end
        end

        grant_d = '0;
        ptr_d   = ptr_q;
        if (found) begin
            grant_d = {{(NREQ-1){1'b0}}, 1'b1} << winner;
            ptr_d   = rr_index(winner, 1);
        end

        // Read from the next-state values so an update on this edge is
        // visible in the registered readback.
        rd_d = '0;
        if (int'(bus.rd_sel) < NREQ) rd_d = cnt_d[bus.rd_sel];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NREQ; j++) cnt_q[j] <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            wrap_q  <= '0;
            rd_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            for (int j = 0; j < NREQ; j++) cnt_q[j] <= cnt_d[j];
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            wrap_q  <= wrap_d;
            rd_q    <= rd_d;
            busy_q  <= |bus.inc_req;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.wrap     = wrap_q;
    assign bus.rd_value = rd_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_counter_bank_scheduler.sv
module tb_counter_bank_scheduler;
    logic clk;
    logic rst;

    counter_bank_if #(.NREQ(4), .WIDTH(4)) bus ();

    counter_bank_scheduler #(.NREQ(4), .WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // scoreboard: expected {grant, wrap} per granted cycle
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: whenever the DUT presents a grant or wrap, pop and compare
    always @(negedge clk) begin
        if (!rst && (bus.grant != 4'b0 || bus.wrap != 4'b0)) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_grant: got grant=%b wrap=%b with nothing expected",
                         bus.grant, bus.wrap);
            end else begin
                check("grant_wrap", {bus.grant, bus.wrap}, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] req, input logic [3:0] g,
                        input logic [3:0] w, input int n);
        bus.inc_req = req;
        repeat (n) begin
            exp_q.push_back({g, w});
            step();
        end
    endtask

    task automatic read_check(input logic [1:0] sel, input logic [3:0] exp);
        bus.rd_sel = sel;
        step();
        check($sformatf("rd_value[%0d]", sel), {4'b0, bus.rd_value}, {4'b0, exp});
    endtask

    initial begin
        rst         = 1'b1;
        bus.inc_req = '0;
        bus.clr_req = '0;
        bus.rd_sel  = '0;
        step();
        step();
        check("reset_grant", {4'b0, bus.grant}, 8'h00);
        check("reset_wrap", {4'b0, bus.wrap}, 8'h00);
        check("reset_rd_value", {4'b0, bus.rd_value}, 8'h00);
        check("reset_busy", {7'b0, bus.busy}, 8'h00);
        rst = 1'b0;

        // round-robin from reset: 0,1,2,3,0,1,2,3
        bus.inc_req = 4'b1111;
        for (int r = 0; r < 2; r++) begin
            hold(4'b1111, 4'b0001, 4'b0, 1);
            hold(4'b1111, 4'b0010, 4'b0, 1);
            hold(4'b1111, 4'b0100, 4'b0, 1);
            hold(4'b1111, 4'b1000, 4'b0, 1);
        end
        check("busy_high", {7'b0, bus.busy}, 8'h01);
        bus.inc_req = '0;
        for (int k = 0; k < 4; k++) read_check(2'(k), 4'd2);
        check("busy_low", {7'b0, bus.busy}, 8'h00);

        // bring counter[2] to 5, then reset asynchronously mid-cycle
        bus.rd_sel = 2'd2;
        hold(4'b0100, 4'b0100, 4'b0, 3);
        check("pre_reset_rd", {4'b0, bus.rd_value}, 8'h05);
        #6;
        rst         = 1'b1;
        bus.inc_req = '0;
        #1;
        check("async_grant", {4'b0, bus.grant}, 8'h00);
        check("async_wrap", {4'b0, bus.wrap}, 8'h00);
        check("async_rd_value", {4'b0, bus.rd_value}, 8'h00);
        check("async_busy", {7'b0, bus.busy}, 8'h00);
        step();
        rst = 1'b0;
        read_check(2'd2, 4'd0);

        // single requester held for 3 cycles
        hold(4'b0010, 4'b0010, 4'b0, 3);
        bus.inc_req = '0;
        read_check(2'd1, 4'd3);

        // wrap on counter[3]
        bus.rd_sel = 2'd3;
        hold(4'b1000, 4'b1000, 4'b0, 15);
        check("cnt3_at_max", {4'b0, bus.rd_value}, 8'h0f);
        hold(4'b1000, 4'b1000, 4'b1000, 1);
        check("cnt3_wrapped", {4'b0, bus.rd_value}, 8'h00);
        bus.inc_req = '0;
        step();
        check("wrap_cleared", {4'b0, bus.wrap}, 8'h00);
        check("grant_cleared", {4'b0, bus.grant}, 8'h00);

        // clear beats increment: counter[0]=7, ptr back at 0
        hold(4'b0001, 4'b0001, 4'b0, 7);
        hold(4'b1000, 4'b1000, 4'b0, 1);
        bus.inc_req = 4'b0011;
        bus.clr_req = 4'b0001;
        exp_q.push_back({4'b0010, 4'b0000});
        step();
        bus.inc_req = '0;
        bus.clr_req = '0;
        read_check(2'd0, 4'd0);
        read_check(2'd1, 4'd4);
        read_check(2'd3, 4'd1);

        // readback forwarding on counter[2]: 4 -> 5
        bus.rd_sel = 2'd2;
        hold(4'b0100, 4'b0100, 4'b0, 4);
        check("fwd_rd_4", {4'b0, bus.rd_value}, 8'h04);
        hold(4'b0100, 4'b0100, 4'b0, 1);
        check("fwd_rd_5", {4'b0, bus.rd_value}, 8'h05);
        bus.inc_req = '0;

        step();
        step();
        check("queue_drained", 8'(exp_q.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
